// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived window bounds and pin-side types.
package vga_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical).
    localparam int VGA_COLOR_BITS = 24;
    localparam int VGA_H_ACTIVE   = 640;
    localparam int VGA_H_FP       = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BP       = 48;
    localparam int VGA_V_ACTIVE   = 480;
    localparam int VGA_V_FP       = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BP       = 33;
    localparam int VGA_CNT_W      = 10;

    // Sum of the four segments of one axis.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = timing_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = timing_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // Sync windows are [start, end): 656..751 and 490..491 for the defaults.
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // One colour channel at the default width.
    typedef logic [VGA_COLOR_BITS/3-1:0] color_t;

    // Everything that leaves the chip towards the DAC in one pixel.
    typedef struct packed {
        color_t red;
        color_t green;
        color_t blue;
        logic   hsync;
        logic   vsync;
        logic   blank_n;
    } vga_out_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical pixel counters with wrap, plus active-area and sync-window decode.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync_act,
    output logic             vsync_act
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // All bounds are inclusive "last" values so they always fit in CNT_W bits,
    // even when a total equals 2**CNT_W exactly.
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // A counter too narrow for the frame would silently alias lines; refuse to build.
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_too_small
        $error("vga_timing_counter: CNT_W=%0d cannot hold H_TOTAL=%0d / V_TOTAL=%0d",
               CNT_W, H_TOTAL, V_TOTAL);
    end

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Raster scan: x advances every pixel tick, y advances on each x wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    assign active    = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
    assign hsync_act = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vsync_act = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA display-timing source: publishes stage-0 coordinates to the renderer and
// registers its colour, with blanking and sync, onto the pins one tick later.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int COLOR_BITS = VGA_COLOR_BITS,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = VGA_CNT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    pix_en_i,
    input  logic [COLOR_BITS/3-1:0] red_i,
    input  logic [COLOR_BITS/3-1:0] green_i,
    input  logic [COLOR_BITS/3-1:0] blue_i,
    output logic [CNT_W-1:0]        x_o,
    output logic [CNT_W-1:0]        y_o,
    output logic                    display_enable_o,
    output logic                    frame_start_o,
    output logic                    line_start_o,
    output logic [COLOR_BITS/3-1:0] vga_red_o,
    output logic [COLOR_BITS/3-1:0] vga_green_o,
    output logic [COLOR_BITS/3-1:0] vga_blue_o,
    output logic                    hsync_o,
    output logic                    vsync_o,
    output logic                    blank_no
);

    localparam int CH_W = COLOR_BITS / 3;

    // Pin bundle at this instance's channel width.
    typedef struct packed {
        logic [CH_W-1:0] red;
        logic [CH_W-1:0] green;
        logic [CH_W-1:0] blue;
        logic            hsync;
        logic            vsync;
        logic            blank_n;
    } pin_t;

    // Pins at rest: black, blanked, both syncs at their inactive level.
    localparam pin_t PIN_RESET = '{
        red:     '0,
        green:   '0,
        blue:    '0,
        hsync:   ~H_SYNC_POL,
        vsync:   ~V_SYNC_POL,
        blank_n: 1'b0
    };

    if (COLOR_BITS % 3 != 0) begin : g_color_bits_bad
        $error("vga_sync_gen: COLOR_BITS=%0d is not a multiple of 3", COLOR_BITS);
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hsync_act;
    logic             vsync_act;
    pin_t             pin_d;
    pin_t             pin_q;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CNT_W    (CNT_W)
    ) u_timing (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .pix_en    (pix_en_i),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .active    (active),
        .hsync_act (hsync_act),
        .vsync_act (vsync_act)
    );

    // Stage 0: coordinates and strobes straight from the counters.
    assign x_o              = h_cnt;
    assign y_o              = v_cnt;
    assign display_enable_o = active;
    assign line_start_o     = pix_en_i && (h_cnt == '0);
    assign frame_start_o    = pix_en_i && (h_cnt == '0) && (v_cnt == '0);

    // Next pin value: renderer colour gated by the active area, syncs mapped to polarity.
    always_comb begin
        // NOTE: pin_d gets a full default before any condition, so no path
        // leaves a bit unassigned and no latch is inferred.
        pin_d         = PIN_RESET;
        pin_d.red     = active ? red_i   : '0;
        pin_d.green   = active ? green_i : '0;
        pin_d.blue    = active ? blue_i  : '0;
        pin_d.hsync   = hsync_act ? H_SYNC_POL : ~H_SYNC_POL;
        pin_d.vsync   = vsync_act ? V_SYNC_POL : ~V_SYNC_POL;
        pin_d.blank_n = active;
    end

    // Stage 1: one register for colour, sync and blank keeps them mutually aligned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pin_q <= PIN_RESET;
        end else if (pix_en_i) begin
            pin_q <= pin_d;
        end
    end

    assign vga_red_o   = pin_q.red;
    assign vga_green_o = pin_q.green;
    assign vga_blue_o  = pin_q.blue;
    assign hsync_o     = pin_q.hsync;
    assign vsync_o     = pin_q.vsync;
    assign blank_no    = pin_q.blank_n;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Display-timing source: generates pixel coordinates and the display-enable strobe that the pixel renderer consumes.
- Takes back the renderer's combinational colour for those coordinates and registers it to the VGA pins together with aligned hsync/vsync/blank.
- Sits between the renderer and the DAC/pins; one instance per display.
- Default timing: 640x480@60 with a 25 MHz pixel tick derived from the system clock.

Parameters:
- COLOR_BITS, 24, total colour width; each channel is COLOR_BITS/3.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_BP, 33, vertical back porch (lines).
- H_SYNC_POL, 0, hsync active level (0 = active low).
- V_SYNC_POL, 0, vsync active level (0 = active low).
- CNT_W, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- pix_en_i  in  1  pixel tick; counters and output registers advance only on clk_i edges where this is 1.
- red_i  in  COLOR_BITS/3  renderer red for current x_o/y_o.
- green_i  in  COLOR_BITS/3  renderer green.
- blue_i  in  COLOR_BITS/3  renderer blue.
- x_o  out  CNT_W  current horizontal count.
- y_o  out  CNT_W  current vertical count.
- display_enable_o  out  1  x_o < H_ACTIVE and y_o < V_ACTIVE (stage 0, combinational from counters).
- frame_start_o  out  1  one-clk pulse: pix_en_i=1 and x_o=0 and y_o=0.
- line_start_o  out  1  one-clk pulse: pix_en_i=1 and x_o=0.
- vga_red_o, vga_green_o, vga_blue_o  out  COLOR_BITS/3 each  registered pixel colour.
- hsync_o  out  1  registered hsync at H_SYNC_POL.
- vsync_o  out  1  registered vsync at V_SYNC_POL.
- blank_no  out  1  registered, 1 = visible pixel.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counter advance, on pix_en_i=1:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At V_TOTAL-1 with h wrap, v_cnt wraps to 0.
  - With pix_en_i=0, all state holds.
- Outputs x_o, y_o and display_enable_o are stage 0; renderer colour for them is valid in the same cycle.
- Sync windows, stage 0, same for vertical using v_cnt:
  - hsync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync active iff 490..491.
- Output stage (stage 1), registered on pix_en_i=1:
  - vga_* = stage-0 colour if display_enable_o, else 0.
  - hsync_o/vsync_o = stage-0 sync mapped to polarity.
  - blank_no = display_enable_o.
- Latency: pin outputs lag coordinates by exactly one pixel tick. Sync, blank and colour stay mutually aligned.
- Blanking is enforced here regardless of renderer output: non-zero colour outside the active area never reaches the pins.
- Reset values:
  - h_cnt=0, v_cnt=0, so x_o=0, y_o=0, display_enable_o=1.
  - vga_*=0, blank_no=0.
  - hsync_o=~H_SYNC_POL, vsync_o=~V_SYNC_POL (inactive).
- Reset mid-frame restarts at (0,0) on the first tick after release; no partial-frame recovery.
- Counter widths: compare in CNT_W bits. Parameters with H_TOTAL or V_TOTAL > 2**CNT_W are illegal (elaboration assertion).
- pix_en_i held 1 every clock is legal: the pixel rate equals the clock rate.

Decomposition:
- Shared package vga_pkg:
  - timing constants H_ACTIVE..V_BP and derived H_TOTAL/V_TOTAL, sync start/end.
  - channel width typedef color_t.
  - struct vga_out_t {red, green, blue, hsync, vsync, blank_n}.
- One natural sub-module, vga_timing_counter: h/v counters, wrap logic, sync/active decode.
- Top level adds the stage-1 output register.

Test Plan:
- Reset release with pix_en_i every 2nd clock: x_o=0,y_o=0; hsync_o=1, vsync_o=1, blank_no=0, vga_*=0. frame_start_o pulses on the first tick; x_o=1 after 2 clocks.
- Full line with pix_en_i=1 constantly:
  - x_o runs 0..799, then wraps to 0 with y_o incrementing.
  - hsync_o low for exactly 96 ticks, first low at the tick after x_o=656.
  - line_start_o pulses every 800 clocks.
- Full frame: vsync_o low during lines 490-491 (delayed one tick); frame_start_o period = 420000 ticks; y_o wraps 524->0.
- Renderer drives constant 8'hFF on all channels:
  - vga_* = FF only where blank_no=1; 0 otherwise.
  - first FF appears one tick after (0,0).
  - blank_no falls one tick after x_o=640.
- Asynchronous reset asserted at (300,200) between clock edges: outputs return to reset values immediately, without waiting for a clock edge. Counting restarts from (0,0).
- Parameter override H_SYNC_POL=1, V_SYNC_POL=1: reset levels 0; sync pulses high with identical timing.
